aes128_iter_core: RTL and testbench

Iterative AES-128 encryption core: accepts one 128-bit plaintext block and key over a valid/ready handshake and runs the ten FIPS-197 rounds on a single shared round datapath. Round keys are expanded on the fly. It returns the ciphertext over a second valid/ready handshake. `SBOX_LANES` trades S-box area against latency. This is the sequential successor to the combinational round-function blocks and is the unit the top-level cipher wrapper instantiates.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/SBox.sv | 40 ++++
 rtl/aes128_key_step.sv | 32 +++
 rtl/aes128_iter_core.sv | 148 ++++++++++++++
 tb/tb_aes128_iter_core.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 core: round count, rcon table,
// FSM state type and the byte-level helpers used by the round datapath.
// State byte k (= row + 4*col) lives at bits [127-8k -: 8].
package aes_pkg;

  localparam int unsigned Nr = 10;

  // rcon[1..10], first entry in the top byte.
  localparam logic [79:0] RconTable = 80'h01_02_04_08_10_20_40_80_1b_36;

  typedef enum logic [1:0] {StIdle, StSub, StMix, StDone} aes_state_e;

  // LSB position of state byte k.
  function automatic int unsigned byte_lsb(int unsigned k);
    return 120 - 8 * k;
  endfunction

  // Returns 0 outside rounds 1..10 so the key step is well defined at any time.
  function automatic logic [7:0] rcon(logic [3:0] round);
    int unsigned idx;
    idx = 32'(round);
    if (idx >= 1 && idx <= Nr) return RconTable[79 - 8 * (idx - 1) -: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column, byte 0 (row 0) in bits [31:24].
  function automatic logic [31:0] mix_column(logic [31:0] col);
    logic [7:0] b0, b1, b2, b3;
    b0 = col[31:24];
    b1 = col[23:16];
    b2 = col[15:8];
    b3 = col[7:0];
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  // Row r is rotated left by r columns.
  function automatic logic [127:0] shift_rows(logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[byte_lsb(r + 4 * c) +: 8] = s[byte_lsb(r + 4 * ((c + r) % 4)) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/SBox.sv
// AES forward S-box, purely combinational.
// Computes the GF(2^8) multiplicative inverse as a^254 and applies the affine map.
//   data_i : input byte
//   data_o : substituted byte
module SBox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // a^2 * a^4 * ... * a^128 = a^254 (zero maps to zero).
  always_comb begin
    logic [7:0] pw;
    pw  = data_i;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
  end

  assign data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes128_key_step.sv
// One step of the AES-128 key schedule (combinational).
//   key_i  : current round key
//   rcon_i : round constant for the step
//   key_o  : next round key
module aes128_key_step (
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] temp;
  logic [31:0] w0, w1, w2, w3;

  assign rot_word = {key_i[23:0], key_i[31:24]};

  for (genvar i = 0; i < 4; i++) begin : gen_sbox
    SBox u_sbox (
      .data_i (rot_word[8*i +: 8]),
      .data_o (sub_word[8*i +: 8])
    );
  end

  assign temp = sub_word ^ {rcon_i, 24'h0};
  assign w0   = key_i[127:96] ^ temp;
  assign w1   = key_i[95:64] ^ w0;
  assign w2   = key_i[63:32] ^ w1;
  assign w3   = key_i[31:0] ^ w2;
  assign key_o = {w0, w1, w2, w3};

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core sharing one round datapath over ten rounds.
// SUB substitutes SBOX_LANES state bytes per cycle; MIX does ShiftRows,
// MixColumns (skipped in round 10) and AddRoundKey with an on-the-fly round key.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : plaintext + key handshake (ready only when idle)
//   in_data, in_key    : plaintext and cipher key
//   out_valid/out_ready: ciphertext handshake, held until accepted
//   out_data           : registered ciphertext
//   busy               : a block is in flight or awaiting collection
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LANES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned Steps = 16 / SBOX_LANES;
  localparam int unsigned LaneW = (Steps > 1) ? $clog2(Steps) : 1;

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
      SBOX_LANES != 8 && SBOX_LANES != 16) begin : gen_bad_lanes
    $error("SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  aes_state_e         st_q, st_d;
  logic [127:0]       state_q, state_d;
  logic [127:0]       key_q, key_d;
  logic [3:0]         round_q, round_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic [127:0]       out_data_q, out_data_d;

  logic [127:0]       next_key;
  logic [127:0]       mix_out;
  logic [127:0]       sr;
  logic [7:0]         sub_in  [SBOX_LANES];
  logic [7:0]         sub_out [SBOX_LANES];

  aes128_key_step u_key_step (
    .key_i  (key_q),
    .rcon_i (rcon(round_q)),
    .key_o  (next_key)
  );

  // Lane counter picks which group of bytes goes through the shared S-boxes.
  always_comb begin
    for (int li = 0; li < int'(SBOX_LANES); li++) begin
      sub_in[li] = state_q[byte_lsb(32'(lane_q) * SBOX_LANES + 32'(li)) +: 8];
    end
  end

  for (genvar li = 0; li < int'(SBOX_LANES); li++) begin : gen_lane
    SBox u_sbox (
      .data_i (sub_in[li]),
      .data_o (sub_out[li])
    );
  end

  always_comb begin
    sr      = shift_rows(state_q);
    mix_out = '0;
    for (int c = 0; c < 4; c++) begin
      mix_out[96 - 32 * c +: 32] = (round_q == 4'(Nr)) ? sr[96 - 32 * c +: 32]
                                                       : mix_column(sr[96 - 32 * c +: 32]);
    end
    mix_out = mix_out ^ next_key;
  end

  always_comb begin
    st_d       = st_q;
    state_d    = state_q;
    key_d      = key_q;
    round_d    = round_q;
    lane_d     = lane_q;
    out_data_d = out_data_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          state_d = in_data ^ in_key;
          key_d   = in_key;
          round_d = 4'd1;
          lane_d  = '0;
          st_d    = StSub;
        end
      end
      StSub: begin
        for (int li = 0; li < int'(SBOX_LANES); li++) begin
          state_d[byte_lsb(32'(lane_q) * SBOX_LANES + 32'(li)) +: 8] = sub_out[li];
        end
        if (lane_q == LaneW'(Steps - 1)) begin
          lane_d = '0;
          st_d   = StMix;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      StMix: begin
        state_d = mix_out;
        key_d   = next_key;
        if (round_q < 4'(Nr)) begin
          round_d = round_q + 4'd1;
          lane_d  = '0;
          st_d    = StSub;
        end else begin
          out_data_d = mix_out;
          st_d       = StDone;
        end
      end
      StDone: begin
        if (out_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= StIdle;
      state_q    <= '0;
      key_q      <= '0;
      round_q    <= '0;
      lane_q     <= '0;
      out_data_q <= '0;
    end else begin
      st_q       <= st_d;
      state_q    <= state_d;
      key_q      <= key_d;
      round_q    <= round_d;
      lane_q     <= lane_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (st_q == StIdle);
  assign out_valid = (st_q == StDone);
  assign busy      = (st_q != StIdle);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: three instances (16, 4 and 1 lanes)
// share stimulus; most scenarios observe the 16-lane instance.
module tb_aes128_iter_core;

  localparam logic [127:0] C1Key  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Pt   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1Ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZeroCt = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_ready = 1'b0;

  logic         in_ready16, out_valid16, busy16;
  logic         in_ready4, out_valid4, busy4;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] out_data16, out_data4, out_data1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes128_iter_core #(.SBOX_LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid16),
    .out_ready(out_ready), .out_data(out_data16), .busy(busy16)
  );

  aes128_iter_core #(.SBOX_LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
  );

  aes128_iter_core #(.SBOX_LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  // Stimulus helpers (no checking inside).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns #1 after the accepting edge.
  task automatic send_block(input logic [127:0] pt, input logic [127:0] key);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges until out_valid16 seen after the accept; -1 on timeout.
  task automatic wait_out(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (out_valid16) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (out_valid16 !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got %b want 0", out_valid16);
    end
    checks++;
    if (out_data16 !== 128'h0) begin
      failures++; $display("FAIL reset_out_data got %h want 0", out_data16);
    end
    checks++;
    if (busy16 !== 1'b0) begin
      failures++; $display("FAIL reset_busy got %b want 0", busy16);
    end
    checks++;
    if (in_ready16 !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b want 1", in_ready16);
    end
    checks++;
    if (in_ready4 !== 1'b1 || in_ready1 !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready_lanes got %b%b want 11", in_ready4, in_ready1);
    end
  endtask

  task automatic test_latency_lanes();
    int lat16, lat4, lat1;
    lat16 = -1; lat4 = -1; lat1 = -1;
    send_block(C1Pt, C1Key);
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (out_valid16 && lat16 < 0) lat16 = i;
      if (out_valid4 && lat4 < 0) lat4 = i;
      if (out_valid1 && lat1 < 0) lat1 = i;
    end
    checks++;
    if (lat16 !== 20) begin
      failures++; $display("FAIL latency_l16 got %0d want 20", lat16);
    end
    checks++;
    if (lat4 !== 50) begin
      failures++; $display("FAIL latency_l4 got %0d want 50", lat4);
    end
    checks++;
    if (lat1 !== 170) begin
      failures++; $display("FAIL latency_l1 got %0d want 170", lat1);
    end
    checks++;
    if (out_data16 !== C1Ct) begin
      failures++; $display("FAIL c1_ct_l16 got %h want %h", out_data16, C1Ct);
    end
    checks++;
    if (out_data4 !== C1Ct) begin
      failures++; $display("FAIL c1_ct_l4 got %h want %h", out_data4, C1Ct);
    end
    checks++;
    if (out_data1 !== C1Ct) begin
      failures++; $display("FAIL c1_ct_l1 got %h want %h", out_data1, C1Ct);
    end
    pop();
  endtask

  task automatic test_zero_vector();
    int n;
    send_block(128'h0, 128'h0);
    wait_out(n);
    checks++;
    if (n !== 20 || out_data16 !== ZeroCt) begin
      failures++;
      $display("FAIL zero_vector got %h after %0d edges want %h after 20", out_data16, n, ZeroCt);
    end
    pop();
  endtask

  task automatic test_backpressure();
    int n;
    send_block(C1Pt, C1Key);
    wait_out(n);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 128'hdeadbeef_00000000_12345678_9abcdef0;
      in_key   = 128'h0;
      checks++;
      if (out_valid16 !== 1'b1) begin
        failures++; $display("FAIL bp_out_valid cycle %0d got %b want 1", i, out_valid16);
      end
      checks++;
      if (out_data16 !== C1Ct) begin
        failures++; $display("FAIL bp_out_data cycle %0d got %h want %h", i, out_data16, C1Ct);
      end
      checks++;
      if (in_ready16 !== 1'b0) begin
        failures++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready16);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready16, out_valid16);
    end
    send_block(C1Pt, C1Key);
    wait_out(n);
    checks++;
    if (n !== 20 || out_data16 !== C1Ct) begin
      failures++;
      $display("FAIL b2b_ct got %h after %0d edges want %h after 20", out_data16, n, C1Ct);
    end
    pop();
  endtask

  task automatic test_ignore_midflight();
    int n;
    n = -1;
    send_block(C1Pt, C1Key);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      in_valid = (i < 15);
      in_data  = 128'hffffffff_ffffffff_ffffffff_ffffffff;
      in_key   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      @(posedge clk);
      #1;
      if (out_valid16) begin
        n = i;
        break;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 20) begin
      failures++; $display("FAIL midflight_latency got %0d want 20", n);
    end
    checks++;
    if (out_data16 !== C1Ct) begin
      failures++; $display("FAIL midflight_ct got %h want %h", out_data16, C1Ct);
    end
    pop();
  endtask

  task automatic test_reset_midround();
    int n;
    send_block(C1Pt, C1Key);
    repeat (8) @(posedge clk);  // now in round 5 SUB for the 16-lane core
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy16 !== 1'b0) begin
      failures++; $display("FAIL rst_mid_busy got %b want 0", busy16);
    end
    checks++;
    if (out_valid16 !== 1'b0) begin
      failures++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid16);
    end
    checks++;
    if (in_ready16 !== 1'b1) begin
      failures++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready16);
    end
    @(negedge clk);
    rst = 1'b0;
    send_block(C1Pt, C1Key);
    wait_out(n);
    checks++;
    if (n !== 20) begin
      failures++; $display("FAIL rst_mid_latency got %0d want 20", n);
    end
    checks++;
    if (out_data16 !== C1Ct) begin
      failures++; $display("FAIL rst_mid_ct got %h want %h", out_data16, C1Ct);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_latency_lanes();
    test_zero_vector();
    test_backpressure();
    test_ignore_midflight();
    test_reset_midround();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
